// File: rtl/exec_stage_if.sv
// Execute-stage bus: decode-side inputs, bubble/status controls, and the
// combinational e_* and registered M_* results of the Execute stage.
interface exec_stage_if #(parameter int W = 64);
  logic [1:0]   D_stat;
  logic [3:0]   D_iCode;
  logic [3:0]   D_iFun;
  logic [W-1:0] D_valC;
  logic [W-1:0] D_valA;
  logic [W-1:0] D_valB;
  logic [3:0]   D_dstE;
  logic [3:0]   D_dstM;
  logic         E_bubble;
  logic         M_bubble;
  logic [1:0]   m_stat;
  logic [1:0]   W_stat;
  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_Cnd;
  logic [1:0]   M_stat;
  logic [3:0]   M_iCode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;
  logic [2:0]   cc_out;

  modport master (
    output D_stat, D_iCode, D_iFun, D_valC, D_valA, D_valB, D_dstE, D_dstM,
    output E_bubble, M_bubble, m_stat, W_stat,
    input  e_valE, e_dstE, e_Cnd,
    input  M_stat, M_iCode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
  );

  modport slave (
    input  D_stat, D_iCode, D_iFun, D_valC, D_valA, D_valB, D_dstE, D_dstM,
    input  E_bubble, M_bubble, m_stat, W_stat,
    output e_valE, e_dstE, e_Cnd,
    output M_stat, M_iCode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
  );
endinterface

// File: rtl/exec_stage.sv
// Y86-64 Execute stage: D->E register, ALU, condition codes, E->M register.
// e_valE / e_dstE / e_Cnd are combinational so decode can forward them.
module exec_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_stage_if.slave  bus
);

  localparam logic [1:0] S_AOK   = 2'd0;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [2:0] CC_RST  = 3'b100;
  localparam logic signed [W-1:0] STACK_STEP = W'(8);

  // E register
  logic [1:0]          stat_p0;
  logic [3:0]          icode_p0, ifun_p0;
  logic signed [W-1:0] valc_p0, vala_p0, valb_p0;
  logic [3:0]          dste_p0, dstm_p0;
  logic [2:0]          cc_p0;

  // M register
  logic [1:0]          stat_p1;
  logic [3:0]          icode_p1;
  logic                cnd_p1;
  logic signed [W-1:0] vale_p1, vala_p1;
  logic [3:0]          dste_p1, dstm_p1;

  logic signed [W-1:0] alu_a, alu_b, alu_res;
  logic [3:0]          alu_fun;
  logic [2:0]          alu_cc;
  logic                e_cnd, set_cc;
  logic [3:0]          e_dste;

  function automatic logic signed [W-1:0] alu_op(input logic [3:0] fun,
                                                 input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    case (fun)
      ALU_ADD: return b + a;
      ALU_SUB: return b - a;
      ALU_AND: return b & a;
      ALU_XOR: return b ^ a;
      default: return '0;
    endcase
  endfunction

  // Overflow is judged on operand/result signs; logical ops never overflow.
  function automatic logic [2:0] alu_flags(input logic [3:0] fun,
                                           input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b,
                                           input logic signed [W-1:0] r);
    logic of;
    case (fun)
      ALU_ADD: of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      ALU_SUB: of = (b[W-1] != a[W-1]) && (r[W-1] != b[W-1]);
      default: of = 1'b0;
    endcase
    return {r == '0, r[W-1], of};
  endfunction

  function automatic logic cond_eval(input logic [3:0] fun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (fun)
      4'd0:    return 1'b1;
      4'd1:    return (sf ^ of) | zf;
      4'd2:    return sf ^ of;
      4'd3:    return zf;
      4'd4:    return ~zf;
      4'd5:    return ~(sf ^ of);
      4'd6:    return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode_p0)
      I_CMOV, I_OPQ:             alu_a = vala_p0;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = valc_p0;
      I_CALL, I_PUSH:            alu_a = -STACK_STEP;
      I_RET, I_POP:              alu_a = STACK_STEP;
      default:                   alu_a = '0;
    endcase
    case (icode_p0)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = valb_p0;
      default:                                               alu_b = '0;
    endcase
  end

  assign alu_fun = (icode_p0 == I_OPQ) ? ifun_p0 : ALU_ADD;
  assign alu_res = alu_op(alu_fun, alu_a, alu_b);
  assign alu_cc  = alu_flags(alu_fun, alu_a, alu_b, alu_res);
  assign e_cnd   = (icode_p0 == I_CMOV || icode_p0 == I_JXX) ? cond_eval(ifun_p0, cc_p0) : 1'b1;
  assign e_dste  = (icode_p0 == I_CMOV && !e_cnd) ? R_NONE : dste_p0;
  // Any faulting instruction in E, M or W must not disturb the flags.
  assign set_cc  = (icode_p0 == I_OPQ) && (stat_p0 == S_AOK) &&
                   (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_p0  <= S_AOK;
      icode_p0 <= I_NOP;
      ifun_p0  <= '0;
      valc_p0  <= '0;
      vala_p0  <= '0;
      valb_p0  <= '0;
      dste_p0  <= R_NONE;
      dstm_p0  <= R_NONE;
      stat_p1  <= S_AOK;
      icode_p1 <= I_NOP;
      cnd_p1   <= 1'b0;
      vale_p1  <= '0;
      vala_p1  <= '0;
      dste_p1  <= R_NONE;
      dstm_p1  <= R_NONE;
      cc_p0    <= CC_RST;
    end else begin
      if (bus.E_bubble) begin
        stat_p0  <= S_AOK;
        icode_p0 <= I_NOP;
        ifun_p0  <= '0;
        valc_p0  <= '0;
        vala_p0  <= '0;
        valb_p0  <= '0;
        dste_p0  <= R_NONE;
        dstm_p0  <= R_NONE;
      end else begin
        stat_p0  <= bus.D_stat;
        icode_p0 <= bus.D_iCode;
        ifun_p0  <= bus.D_iFun;
        valc_p0  <= bus.D_valC;
        vala_p0  <= bus.D_valA;
        valb_p0  <= bus.D_valB;
        dste_p0  <= bus.D_dstE;
        dstm_p0  <= bus.D_dstM;
      end
      if (bus.M_bubble) begin
        stat_p1  <= S_AOK;
        icode_p1 <= I_NOP;
        cnd_p1   <= 1'b0;
        vale_p1  <= '0;
        vala_p1  <= '0;
        dste_p1  <= R_NONE;
        dstm_p1  <= R_NONE;
      end else begin
        stat_p1  <= stat_p0;
        icode_p1 <= icode_p0;
        cnd_p1   <= e_cnd;
        vale_p1  <= alu_res;
        vala_p1  <= vala_p0;
        dste_p1  <= e_dste;
        dstm_p1  <= dstm_p0;
      end
      if (set_cc) cc_p0 <= alu_cc;
    end
  end

  assign bus.e_valE  = alu_res;
  assign bus.e_dstE  = e_dste;
  assign bus.e_Cnd   = e_cnd;
  assign bus.M_stat  = stat_p1;
  assign bus.M_iCode = icode_p1;
  assign bus.M_Cnd   = cnd_p1;
  assign bus.M_valE  = vale_p1;
  assign bus.M_valA  = vala_p1;
  assign bus.M_dstE  = dste_p1;
  assign bus.M_dstM  = dstm_p1;
  assign bus.cc_out  = cc_p0;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: a reference model predicts e_*, M_* and CC
// for each issued instruction; M results are popped two edges after issue.
module tb_exec_stage;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exec_stage_if #(.W(W)) bus();
  exec_stage #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        ebub;
    logic        mbub;
    logic [1:0]  mst;
    logic [1:0]  wst;
  } instr_t;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } m_t;

  m_t          sb[$];
  logic [2:0]  tb_cc;
  logic [2:0]  exp_cc;
  logic [63:0] exp_vale;
  logic [3:0]  exp_dste;
  logic        exp_cnd;
  int          checks = 0;
  int          errors = 0;

  function automatic instr_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] valc, input logic [63:0] vala,
                                input logic [63:0] valb, input logic [3:0] dste,
                                input logic [3:0] dstm);
    instr_t x;
    x = '0;
    x.icode = icode; x.ifun = ifun; x.valc = valc; x.vala = vala; x.valb = valb;
    x.dste = dste; x.dstm = dstm;
    return x;
  endfunction

  function automatic m_t m_bubble_entry(input logic cnd);
    m_t e;
    e = '0;
    e.icode = 4'h1; e.cnd = cnd; e.dste = 4'hF; e.dstm = 4'hF;
    return e;
  endfunction

  function automatic m_t m_now();
    m_t e;
    e.stat = bus.M_stat; e.icode = bus.M_iCode; e.cnd = bus.M_Cnd;
    e.vale = bus.M_valE; e.vala = bus.M_valA; e.dste = bus.M_dstE; e.dstm = bus.M_dstM;
    return e;
  endfunction

  function automatic logic [63:0] model_vale(input instr_t x);
    case (x.icode)
      4'h2:       return x.vala;
      4'h3:       return x.valc;
      4'h4, 4'h5: return x.valb + x.valc;
      4'h6: case (x.ifun)
              4'd0:    return x.valb + x.vala;
              4'd1:    return x.valb - x.vala;
              4'd2:    return x.valb & x.vala;
              4'd3:    return x.valb ^ x.vala;
              default: return 64'd0;
            endcase
      4'h8, 4'hA: return x.valb - 64'd8;
      4'h9, 4'hB: return x.valb + 64'd8;
      default:    return 64'd0;
    endcase
  endfunction

  // Flags via 65-bit sign-extended arithmetic: overflow iff the top two bits differ.
  function automatic logic [2:0] model_flags(input instr_t x, input logic [63:0] r);
    logic [64:0] wide;
    logic        of;
    of = 1'b0;
    if (x.ifun == 4'd0) begin
      wide = {x.valb[63], x.valb} + {x.vala[63], x.vala};
      of = wide[64] ^ wide[63];
    end else if (x.ifun == 4'd1) begin
      wide = {x.valb[63], x.valb} - {x.vala[63], x.vala};
      of = wide[64] ^ wide[63];
    end
    return {(r == 64'd0), r[63], of};
  endfunction

  function automatic logic model_cnd(input logic [3:0] icode, input logic [3:0] ifun,
                                     input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[2]; sf = cc[1]; of = cc[0];
    if (icode != 4'h2 && icode != 4'h7) return 1'b1;
    case (ifun)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic reset_pulse();
    rst_n = 1'b0;
    bus.E_bubble = 1'b0; bus.M_bubble = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.m_stat = 2'd0; bus.W_stat = 2'd0;
    sb.delete();
    sb.push_back(m_bubble_entry(1'b1));
    tb_cc = 3'b100;
  endtask

  // Drives one instruction into E and predicts everything it produces.
  task automatic issue(input instr_t in);
    instr_t x;
    m_t     e;
    bus.D_stat = in.stat; bus.D_iCode = in.icode; bus.D_iFun = in.ifun;
    bus.D_valC = in.valc; bus.D_valA = in.vala; bus.D_valB = in.valb;
    bus.D_dstE = in.dste; bus.D_dstM = in.dstm;
    bus.E_bubble = in.ebub; bus.M_bubble = in.mbub;
    if (in.mbub && sb.size() > 0) sb[sb.size()-1] = m_bubble_entry(1'b0);
    @(posedge clk); #1;
    bus.E_bubble = 1'b0; bus.M_bubble = 1'b0;
    bus.m_stat = in.mst; bus.W_stat = in.wst;
    x = in;
    if (in.ebub) x = mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    exp_cc   = tb_cc;
    exp_vale = model_vale(x);
    exp_cnd  = model_cnd(x.icode, x.ifun, tb_cc);
    exp_dste = (x.icode == 4'h2 && !exp_cnd) ? 4'hF : x.dste;
    e.stat = x.stat; e.icode = x.icode; e.cnd = exp_cnd; e.vale = exp_vale;
    e.vala = x.vala; e.dste = exp_dste; e.dstm = x.dstm;
    sb.push_back(e);
    if (x.icode == 4'h6 && x.stat == 2'd0 && in.mst == 2'd0 && in.wst == 2'd0)
      tb_cc = model_flags(x, exp_vale);
  endtask

  task automatic test_reset();
    instr_t x;
    m_t got, want;
    bus.D_stat = 2'd3; bus.D_iCode = 4'h6; bus.D_iFun = 4'h1; bus.D_valC = 64'hDEAD;
    bus.D_valA = 64'h1234; bus.D_valB = 64'h5678; bus.D_dstE = 4'h2; bus.D_dstM = 4'h3;
    bus.m_stat = 2'd0; bus.W_stat = 2'd0;
    reset_pulse();
    checks++; if (bus.M_iCode !== 4'h1) begin errors++; $display("FAIL reset_icode got=%h want=1", bus.M_iCode); end
    checks++; if (bus.M_dstE !== 4'hF) begin errors++; $display("FAIL reset_dstE got=%h want=f", bus.M_dstE); end
    checks++; if (bus.M_dstM !== 4'hF) begin errors++; $display("FAIL reset_dstM got=%h want=f", bus.M_dstM); end
    checks++; if (bus.cc_out !== 3'b100) begin errors++; $display("FAIL reset_cc got=%b want=100", bus.cc_out); end
    checks++; if (bus.M_Cnd !== 1'b0 || bus.M_valE !== 64'd0 || bus.M_stat !== 2'd0) begin
      errors++; $display("FAIL reset_misc got=%b/%h/%h want=0/0/0", bus.M_Cnd, bus.M_valE, bus.M_stat); end
    // Reset arriving while an OPq sits in E must win over its CC update.
    x = mk(4'h6, 4'h0, 64'd0, 64'd3, 64'd4, 4'h1, 4'hF);
    issue(x);
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_m got=%h want=%h", got, want); end
    reset_pulse();
    checks++; if (bus.cc_out !== 3'b100 || bus.M_iCode !== 4'h1 || bus.M_valE !== 64'd0) begin
      errors++; $display("FAIL reset_mid got=%b/%h/%h want=100/1/0", bus.cc_out, bus.M_iCode, bus.M_valE); end
  endtask

  task automatic test_add();
    m_t got, want;
    issue(mk(4'h6, 4'h0, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF));
    checks++; if (bus.e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_valE got=%h want=8000000000000000", bus.e_valE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL add_m0 got=%h want=%h", got, want); end
    issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF));
    checks++; if (bus.cc_out !== 3'b011) begin errors++; $display("FAIL add_cc got=%b want=011", bus.cc_out); end
    checks++; if (bus.M_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_MvalE got=%h want=8000000000000000", bus.M_valE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL add_m1 got=%h want=%h", got, want); end
  endtask

  task automatic test_sub_cmov();
    m_t got, want;
    issue(mk(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF));
    checks++; if (bus.e_valE !== 64'd0) begin errors++; $display("FAIL sub_valE got=%h want=0", bus.e_valE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL sub_m got=%h want=%h", got, want); end
    issue(mk(4'h2, 4'h4, 64'd0, 64'h77, 64'd0, 4'h3, 4'hF));
    checks++; if (bus.cc_out !== 3'b100) begin errors++; $display("FAIL sub_cc got=%b want=100", bus.cc_out); end
    checks++; if (bus.e_Cnd !== 1'b0) begin errors++; $display("FAIL cmovne_cnd got=%b want=0", bus.e_Cnd); end
    checks++; if (bus.e_dstE !== 4'hF) begin errors++; $display("FAIL cmovne_dstE got=%h want=f", bus.e_dstE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL cmov_m0 got=%h want=%h", got, want); end
    issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF));
    checks++; if (bus.M_dstE !== 4'hF) begin errors++; $display("FAIL cmovne_MdstE got=%h want=f", bus.M_dstE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL cmov_m1 got=%h want=%h", got, want); end
  endtask

  task automatic test_stack();
    m_t got, want;
    logic [3:0]  ops [4] = '{4'hA, 4'hB, 4'h8, 4'h9};
    logic [63:0] res [4] = '{64'hF8, 64'h108, 64'hF8, 64'h108};
    for (int i = 0; i < 4; i++) begin
      issue(mk(ops[i], 4'h0, 64'd0, 64'h55, 64'h100, 4'h4, (ops[i] == 4'hB) ? 4'h3 : 4'hF));
      checks++; if (bus.e_valE !== res[i]) begin errors++; $display("FAIL stack_valE op=%h got=%h want=%h", ops[i], bus.e_valE, res[i]); end
      got = m_now(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL stack_m got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_cc_gating();
    m_t got, want;
    instr_t x;
    for (int g = 0; g < 3; g++) begin
      issue(mk(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2, 4'hF));
      got = m_now(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL gate_m0 got=%h want=%h", got, want); end
      x = mk(4'h6, 4'h1, 64'd0, 64'd7, 64'd7, 4'h2, 4'hF);
      if (g == 0) x.mst = 2'd2;
      if (g == 1) x.wst = 2'd3;
      if (g == 2) x.stat = 2'd1;
      issue(x);
      got = m_now(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL gate_m1 got=%h want=%h", got, want); end
      issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF));
      checks++; if (bus.cc_out !== 3'b000) begin errors++; $display("FAIL gate_hold case=%0d got=%b want=000", g, bus.cc_out); end
      checks++; if (bus.M_stat !== x.stat) begin errors++; $display("FAIL gate_stat case=%0d got=%h want=%h", g, bus.M_stat, x.stat); end
      got = m_now(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL gate_m2 got=%h want=%h", got, want); end
    end
    issue(mk(4'h6, 4'h1, 64'd0, 64'd7, 64'd7, 4'h2, 4'hF));
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL gate_m3 got=%h want=%h", got, want); end
    issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF));
    checks++; if (bus.cc_out !== 3'b100) begin errors++; $display("FAIL gate_aok got=%b want=100", bus.cc_out); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL gate_m4 got=%h want=%h", got, want); end
  endtask

  task automatic test_bubbles_jump();
    m_t got, want;
    instr_t x;
    x = mk(4'h3, 4'h0, 64'h42, 64'd0, 64'd0, 4'h2, 4'hF);
    x.ebub = 1'b1;
    issue(x);
    checks++; if (bus.e_valE !== 64'd0) begin errors++; $display("FAIL ebub_valE got=%h want=0", bus.e_valE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL ebub_m0 got=%h want=%h", got, want); end
    issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF));
    checks++; if (bus.M_iCode !== 4'h1 || bus.M_dstE !== 4'hF) begin
      errors++; $display("FAIL ebub_M got=%h/%h want=1/f", bus.M_iCode, bus.M_dstE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL ebub_m1 got=%h want=%h", got, want); end
    issue(mk(4'h3, 4'h0, 64'h42, 64'd0, 64'd0, 4'h2, 4'hF));
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mbub_m0 got=%h want=%h", got, want); end
    x = mk(4'h3, 4'h0, 64'h99, 64'd0, 64'd0, 4'h5, 4'hF);
    x.ebub = 1'b1; x.mbub = 1'b1;
    issue(x);
    checks++; if (bus.M_iCode !== 4'h1 || bus.M_valE !== 64'd0 || bus.M_Cnd !== 1'b0) begin
      errors++; $display("FAIL mbub_M got=%h/%h/%b want=1/0/0", bus.M_iCode, bus.M_valE, bus.M_Cnd); end
    checks++; if (bus.e_valE !== 64'd0 || bus.e_dstE !== 4'hF) begin
      errors++; $display("FAIL both_bub_e got=%h/%h want=0/f", bus.e_valE, bus.e_dstE); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mbub_m1 got=%h want=%h", got, want); end
    issue(mk(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h2, 4'hF));
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL jmp_m0 got=%h want=%h", got, want); end
    issue(mk(4'h7, 4'h2, 64'h300, 64'h200, 64'd0, 4'hF, 4'hF));
    checks++; if (bus.cc_out !== 3'b010) begin errors++; $display("FAIL jmp_cc got=%b want=010", bus.cc_out); end
    checks++; if (bus.e_Cnd !== 1'b1) begin errors++; $display("FAIL jl_cnd got=%b want=1", bus.e_Cnd); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL jmp_m1 got=%h want=%h", got, want); end
    issue(mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF));
    checks++; if (bus.M_Cnd !== 1'b1) begin errors++; $display("FAIL jl_MCnd got=%b want=1", bus.M_Cnd); end
    got = m_now(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL jmp_m2 got=%h want=%h", got, want); end
  endtask

  task automatic test_back_to_back();
    m_t got, want;
    instr_t x;
    logic [63:0] edgev [4] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    for (int i = 0; i < 60; i++) begin
      x = mk(4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) x.icode = 4'h6;
      if ($urandom_range(0, 3) == 0) x.vala = edgev[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) x.valb = edgev[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) x.stat = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) x.mst  = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) x.wst  = 2'($urandom_range(1, 3));
      x.ebub = ($urandom_range(0, 9) == 0);
      x.mbub = ($urandom_range(0, 9) == 0);
      issue(x);
      checks++; if (bus.e_valE !== exp_vale || bus.e_Cnd !== exp_cnd || bus.e_dstE !== exp_dste) begin
        errors++; $display("FAIL b2b_e i=%0d got=%h/%b/%h want=%h/%b/%h", i, bus.e_valE, bus.e_Cnd, bus.e_dstE, exp_vale, exp_cnd, exp_dste); end
      checks++; if (bus.cc_out !== exp_cc) begin errors++; $display("FAIL b2b_cc i=%0d got=%b want=%b", i, bus.cc_out, exp_cc); end
      got = m_now(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL b2b_m i=%0d got=%h want=%h", i, got, want); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_cmov();
    test_stack();
    test_cc_gating();
    test_bubbles_jump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
